audio_sample_fetcher: RTL and testbench

- Upstream stage of the DAC serializer.
- Walks the synchronous sample ROM (audio_memory) sequentially and compensates for the ROM's fixed read latency.
- Buffers samples in a small FIFO and presents them on a valid/ready interface.
- Decouples ROM addressing from serializer frame timing: the serializer pops one sample per LRCK frame instead of driving ROM addresses itself.

---
 rtl/audio_sample_fetcher_if.sv | 21 ++
 rtl/audio_sample_fetcher.sv | 185 ++++++++++++++++++
 tb/tb_audio_sample_fetcher.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_fetcher_if.sv
// Sample stream interface between the ROM fetcher and the DAC serializer.
// master = fetcher (drives sample and valid), slave = serializer (drives ready).
interface audio_sample_fetcher_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;

    modport master (
        output smp_data,
        output smp_valid,
        input  smp_ready
    );

    modport slave (
        input  smp_data,
        input  smp_valid,
        output smp_ready
    );
endinterface

// File: rtl/audio_sample_fetcher.sv
// Walks the synchronous sample ROM sequentially, hides its read latency with a
// valid shift pipe, and buffers samples in a small FIFO for the serializer.
// Reads are only issued when the FIFO is guaranteed to have room for them
// (occupancy + reads in flight < depth), so the FIFO can never overflow.
module audio_sample_fetcher #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int LAST_ADDR  = 240254,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int LOOP       = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          restart,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_q,
    audio_sample_fetcher_if.master        smp,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Wide enough for occupancy plus up to RD_LAT (<=3) reads in flight.
    localparam int CNT_W = LVL_W + 2;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [RD_LAT-1:0]   pipe_reg, pipe_next;
    logic [DATA_W-1:0]   mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]    count_reg;
    logic                started_reg;

    logic [CNT_W-1:0]    inflight;
    logic                issue;
    logic                push;
    logic                pop;
    logic                empty;
    logic                full;
    logic                addr_at_last;

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == LVL_W'(FIFO_DEPTH));
    assign addr_at_last = (addr_reg == LAST);

    // Count reads currently travelling through the ROM latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_reg[i]);
        end
    end

    // Credit-based issue; restart discards whatever the pipe delivers and any pop.
    assign issue = (state_reg == RUN) && enable &&
                   ((CNT_W'(count_reg) + inflight) < CNT_W'(FIFO_DEPTH));
    assign push  = pipe_reg[RD_LAT-1] && !restart;
    assign pop   = !empty && smp.smp_ready && !restart;

    // Valid pipe: bit 0 takes the new issue, each later bit follows its predecessor.
    genvar gi;
    assign pipe_next[0] = issue;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_pipe
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    endgenerate

    // Latency pipe register; restart drops every outstanding read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_reg <= '0;
        end else if (restart) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    // FIFO storage; no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= rom_q;
        end
    end

    // FIFO pointers, occupancy and the started flag used for underrun reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            started_reg <= 1'b0;
        end else if (restart) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            started_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                started_reg <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Control state and ROM address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    // Next-state and next-address logic; restart overrides everything.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        if (restart) begin
            state_next = IDLE;
            addr_next  = '0;
        end else begin
            if (issue) begin
                addr_next = addr_at_last ? '0 : addr_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (issue && addr_at_last && (LOOP == 0)) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && empty) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign rom_addr      = addr_reg;
    assign fifo_level    = count_reg;
    assign smp.smp_valid = !empty;
    assign smp.smp_data  = empty ? '0 : mem_reg[rd_ptr_reg];
    assign underrun      = (state_reg == RUN) && started_reg && smp.smp_ready && empty;
    assign done          = (state_reg == DONE);

    // The issue credit must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!reset_n) push |-> !full);

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Directed bench for audio_sample_fetcher using three configurations:
//   A: LAST_ADDR=5, LOOP=0, RD_LAT=1  (basic stream, drain/done, underrun)
//   B: LAST_ADDR=5, LOOP=1, RD_LAT=3  (pause with reads in flight, wrap)
//   C: defaults                        (backpressure, restart, async reset)
// Each ROM model returns addr*3 after the configured latency.
module tb_audio_sample_fetcher;

    logic clk;
    logic reset_n;

    logic        enable_a, restart_a, underrun_a, done_a;
    logic [17:0] rom_addr_a;
    logic [15:0] rom_q_a;
    logic [3:0]  level_a;

    logic        enable_b, restart_b, underrun_b, done_b;
    logic [17:0] rom_addr_b;
    logic [15:0] rom_q_b, rom_d1_b, rom_d2_b;
    logic [3:0]  level_b;

    logic        enable_c, restart_c, underrun_c, done_c;
    logic [17:0] rom_addr_c;
    logic [15:0] rom_q_c;
    logic [3:0]  level_c;

    int vectors;
    int miscompares;

    audio_sample_fetcher_if #(.DATA_W(16)) sa ();
    audio_sample_fetcher_if #(.DATA_W(16)) sb ();
    audio_sample_fetcher_if #(.DATA_W(16)) sc ();

    audio_sample_fetcher #(
        .ADDR_W(18), .DATA_W(16), .LAST_ADDR(5), .RD_LAT(1), .FIFO_DEPTH(8), .LOOP(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .restart(restart_a),
        .rom_addr(rom_addr_a), .rom_q(rom_q_a), .smp(sa),
        .fifo_level(level_a), .underrun(underrun_a), .done(done_a)
    );

    audio_sample_fetcher #(
        .ADDR_W(18), .DATA_W(16), .LAST_ADDR(5), .RD_LAT(3), .FIFO_DEPTH(8), .LOOP(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .restart(restart_b),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b), .smp(sb),
        .fifo_level(level_b), .underrun(underrun_b), .done(done_b)
    );

    audio_sample_fetcher #(
        .ADDR_W(18), .DATA_W(16), .LAST_ADDR(240254), .RD_LAT(1), .FIFO_DEPTH(8), .LOOP(1)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .enable(enable_c), .restart(restart_c),
        .rom_addr(rom_addr_c), .rom_q(rom_q_c), .smp(sc),
        .fifo_level(level_c), .underrun(underrun_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: one-cycle for A and C, three-cycle for B.
    always_ff @(posedge clk) begin
        rom_q_a  <= 16'(rom_addr_a * 18'd3);
        rom_q_c  <= 16'(rom_addr_c * 18'd3);
        rom_d1_b <= 16'(rom_addr_b * 18'd3);
        rom_d2_b <= rom_d1_b;
        rom_q_b  <= rom_d2_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        enable_a = 1'b0; restart_a = 1'b0; sa.smp_ready = 1'b0;
        enable_b = 1'b0; restart_b = 1'b0; sb.smp_ready = 1'b0;
        enable_c = 1'b0; restart_c = 1'b0; sc.smp_ready = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_addr",  32'(rom_addr_a), 0);
        check("rst_valid", 32'(sa.smp_valid), 0);
        check("rst_data",  32'(sa.smp_data), 0);
        check("rst_level", 32'(level_a), 0);
        check("rst_done",  32'(done_a), 0);
        check("rst_under", 32'(underrun_a), 0);
        tick();
        reset_n = 1'b1;

        // ---- A: basic stream 0,3,..,15 then DRAIN -> DONE ----
        sa.smp_ready = 1'b1;
        enable_a     = 1'b1;
        tick();                                   // edge E: IDLE -> RUN
        check("A_lat_e0", 32'(sa.smp_valid), 0);
        tick();
        check("A_lat_e1", 32'(sa.smp_valid), 0);
        tick();
        check("A_first_valid", 32'(sa.smp_valid), 1);
        check("A_first_data",  32'(sa.smp_data), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("A_stream_data",  32'(sa.smp_data), 32'(3 * i));
            check("A_stream_under", 32'(underrun_a), 0);
        end
        tick();
        check("A_drain_valid", 32'(sa.smp_valid), 0);
        check("A_drain_done",  32'(done_a), 0);
        check("A_drain_under", 32'(underrun_a), 0);
        tick();
        check("A_done",      32'(done_a), 1);
        check("A_done_addr", 32'(rom_addr_a), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("A_done_hold",  32'(done_a), 1);
            check("A_done_under", 32'(underrun_a), 0);
        end

        // ---- A: restart, then starve in RUN to see underrun pulses ----
        restart_a = 1'b1;
        enable_a  = 1'b0;
        tick();
        restart_a = 1'b0;
        check("A_rs_done",  32'(done_a), 0);
        check("A_rs_level", 32'(level_a), 0);
        enable_a = 1'b1;
        tick();
        tick();
        check("A2_lat", 32'(sa.smp_valid), 0);
        tick();
        check("A2_first", 32'(sa.smp_data), 0);
        enable_a = 1'b0;                          // addr 1 still in flight
        tick();
        check("A2_inflight_data", 32'(sa.smp_data), 3);
        check("A2_no_under",      32'(underrun_a), 0);
        tick();
        check("A2_starve_valid", 32'(sa.smp_valid), 0);
        check("A2_under_1",      32'(underrun_a), 1);
        tick();
        check("A2_under_2",   32'(underrun_a), 1);
        check("A2_held_addr", 32'(rom_addr_a), 2);
        enable_a = 1'b1;
        tick();
        check("A2_under_3", 32'(underrun_a), 1);
        tick();
        check("A2_resume_data",  32'(sa.smp_data), 6);
        check("A2_resume_under", 32'(underrun_a), 0);
        enable_a     = 1'b0;
        sa.smp_ready = 1'b0;

        // ---- B: pause with 3 reads in flight (RD_LAT=3), then wrap ----
        sb.smp_ready = 1'b1;
        enable_b     = 1'b1;
        tick();                                   // edge E
        tick();
        tick();
        tick();                                   // E+3: addr 0,1,2 in flight
        enable_b = 1'b0;
        check("B_lat_valid",  32'(sb.smp_valid), 0);
        check("B_pause_addr", 32'(rom_addr_b), 3);
        tick();
        check("B_first_data", 32'(sb.smp_data), 0);
        check("B_first_valid", 32'(sb.smp_valid), 1);
        tick();
        check("B_flight_1", 32'(sb.smp_data), 3);
        tick();
        check("B_flight_2", 32'(sb.smp_data), 6);
        tick();
        check("B_paused_valid", 32'(sb.smp_valid), 0);
        check("B_paused_addr",  32'(rom_addr_b), 3);
        enable_b = 1'b1;
        tick();
        check("B_resume_addr", 32'(rom_addr_b), 4);
        tick();
        tick();
        check("B_resume_wait", 32'(sb.smp_valid), 0);
        tick();
        check("B_resume_data", 32'(sb.smp_data), 9);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("B_wrap_data", 32'(sb.smp_data), 32'(3 * ((3 + k) % 6)));
            check("B_wrap_done", 32'(done_b), 0);
        end
        enable_b     = 1'b0;
        sb.smp_ready = 1'b0;

        // ---- C: backpressure, FIFO saturates at 8 ----
        enable_c = 1'b1;
        tick();                                   // edge E
        tick();
        tick();
        check("C_fill_level1", 32'(level_c), 1);
        repeat (8) tick();
        check("C_full_level", 32'(level_c), 8);
        check("C_full_addr",  32'(rom_addr_c), 8);
        check("C_full_data",  32'(sc.smp_data), 0);
        for (int r = 0; r < 3; r++) begin
            sc.smp_ready = 1'b1;
            check("C_bp_head", 32'(sc.smp_data), 32'(3 * r));
            tick();
            sc.smp_ready = 1'b0;
            check("C_bp_lvl_a", 32'(level_c), 7);
            tick();
            check("C_bp_lvl_b", 32'(level_c), 7);
            tick();
            check("C_bp_lvl_c", 32'(level_c), 8);
            tick();
            check("C_bp_lvl_d", 32'(level_c), 8);
        end
        check("C_bp_addr", 32'(rom_addr_c), 11);

        // ---- C: restart with 5 in FIFO and 1 in flight ----
        enable_c     = 1'b0;
        sc.smp_ready = 1'b1;
        check("C_pop_head0", 32'(sc.smp_data), 9);
        tick();
        check("C_pop_head1", 32'(sc.smp_data), 12);
        tick();
        check("C_pop_head2", 32'(sc.smp_data), 15);
        tick();
        check("C_pop_level", 32'(level_c), 5);
        check("C_pop_head3", 32'(sc.smp_data), 18);
        enable_c     = 1'b1;
        sc.smp_ready = 1'b0;
        tick();
        check("C_pre_rs_level", 32'(level_c), 5);
        check("C_pre_rs_addr",  32'(rom_addr_c), 12);
        restart_c = 1'b1;
        enable_c  = 1'b0;
        tick();
        restart_c = 1'b0;
        check("C_rs_level", 32'(level_c), 0);
        check("C_rs_valid", 32'(sc.smp_valid), 0);
        check("C_rs_data",  32'(sc.smp_data), 0);
        check("C_rs_addr",  32'(rom_addr_c), 0);
        tick();
        check("C_rs_discard", 32'(level_c), 0);
        enable_c     = 1'b1;
        sc.smp_ready = 1'b1;
        tick();
        tick();
        check("C_rerun_lat", 32'(sc.smp_valid), 0);
        tick();
        check("C_rerun_valid", 32'(sc.smp_valid), 1);
        check("C_rerun_data",  32'(sc.smp_data), 0);
        tick();
        check("C_rerun_next", 32'(sc.smp_data), 3);

        // ---- C: asynchronous reset mid-RUN ----
        #3;
        reset_n = 1'b0;
        #1;
        check("C_arst_addr",  32'(rom_addr_c), 0);
        check("C_arst_valid", 32'(sc.smp_valid), 0);
        check("C_arst_data",  32'(sc.smp_data), 0);
        check("C_arst_level", 32'(level_c), 0);
        check("C_arst_under", 32'(underrun_c), 0);
        check("C_arst_done",  32'(done_c), 0);
        tick();
        check("C_arst_hold", 32'(rom_addr_c), 0);
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
